serial_subtractor: RTL

Bit-serial unsigned subtractor: accepts two WIDTH-bit operands over a valid/ready handshake, computes x − y LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow, then presents difference and borrow-out until the consumer accepts them. It is the inverse-operation companion to the team's combinational adder cells and serves as the sequential arithmetic unit in small datapaths where area matters more than latency.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_fs.sv | 13 +
 rtl/serial_subtractor.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding,
// default operand width and the counter-width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must index 0..w-1; a one-bit operand still needs one counter bit.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational full-subtractor cell: d = a - b - bin, bout set on underflow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: x - y computed LSB-first through a single
// full-subtractor cell, one bit per clock, behind valid/ready handshakes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_x_sr;
    logic [WIDTH-1:0] r_y_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic w_d;
    logic w_bout;
    logic w_last;

    full_subtractor u_fs (
        .a    (r_x_sr[0]),
        .b    (r_y_sr[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // which is what lets the shift registers and borrow advance in lockstep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            // NOTE: data registers are reset too because a reset must also
            // clear the visible diff/borrow, not just the control state.
            r_x_sr      <= '0;
            r_y_sr      <= '0;
            r_diff_sr   <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x_sr     <= x;
                        r_y_sr     <= y;
                        r_diff_sr  <= '0;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_x_sr    <= r_x_sr >> 1;
                    r_y_sr    <= r_y_sr >> 1;
                    // The MSB write below overrides the zero shifted in.
                    r_diff_sr <= r_diff_sr >> 1;
                    r_diff_sr[WIDTH-1] <= w_d;
                    r_borrow  <= w_bout;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff_sr;
    assign borrow    = r_borrow;

endmodule
